// File: rtl/decode_pkg.sv
// Shared MIPS decode constants: opcode, funct, REGIMM and COP0 selectors,
// instruction class codes and exception codes.
package decode_pkg;

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpBlez    = 6'h06;
    localparam logic [5:0] OpBgtz    = 6'h07;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0A;
    localparam logic [5:0] OpSltiu   = 6'h0B;
    localparam logic [5:0] OpAndi    = 6'h0C;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpXori    = 6'h0E;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] OpCop0    = 6'h10;
    localparam logic [5:0] OpBeql    = 6'h14;
    localparam logic [5:0] OpBnel    = 6'h15;
    localparam logic [5:0] OpBlezl   = 6'h16;
    localparam logic [5:0] OpBgtzl   = 6'h17;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLwl     = 6'h22;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpLhu     = 6'h25;
    localparam logic [5:0] OpLwr     = 6'h26;
    localparam logic [5:0] OpSb      = 6'h28;
    localparam logic [5:0] OpSh      = 6'h29;
    localparam logic [5:0] OpSwl     = 6'h2A;
    localparam logic [5:0] OpSw      = 6'h2B;
    localparam logic [5:0] OpSwr     = 6'h2E;

    // SPECIAL funct codes
    localparam logic [5:0] FnSll     = 6'h00;
    localparam logic [5:0] FnSrl     = 6'h02;
    localparam logic [5:0] FnSra     = 6'h03;
    localparam logic [5:0] FnSllv    = 6'h04;
    localparam logic [5:0] FnSrlv    = 6'h06;
    localparam logic [5:0] FnSrav    = 6'h07;
    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnJalr    = 6'h09;
    localparam logic [5:0] FnSyscall = 6'h0C;
    localparam logic [5:0] FnBreak   = 6'h0D;
    localparam logic [5:0] FnMfhi    = 6'h10;
    localparam logic [5:0] FnMthi    = 6'h11;
    localparam logic [5:0] FnMflo    = 6'h12;
    localparam logic [5:0] FnMtlo    = 6'h13;
    localparam logic [5:0] FnMult    = 6'h18;
    localparam logic [5:0] FnMultu   = 6'h19;
    localparam logic [5:0] FnDiv     = 6'h1A;
    localparam logic [5:0] FnDivu    = 6'h1B;
    localparam logic [5:0] FnAdd     = 6'h20;
    localparam logic [5:0] FnAddu    = 6'h21;
    localparam logic [5:0] FnSub     = 6'h22;
    localparam logic [5:0] FnSubu    = 6'h23;
    localparam logic [5:0] FnAnd     = 6'h24;
    localparam logic [5:0] FnOr      = 6'h25;
    localparam logic [5:0] FnXor     = 6'h26;
    localparam logic [5:0] FnNor     = 6'h27;
    localparam logic [5:0] FnSlt     = 6'h2A;
    localparam logic [5:0] FnSltu    = 6'h2B;
    localparam logic [5:0] FnTge     = 6'h30;
    localparam logic [5:0] FnTgeu    = 6'h31;
    localparam logic [5:0] FnTlt     = 6'h32;
    localparam logic [5:0] FnTltu    = 6'h33;
    localparam logic [5:0] FnTeq     = 6'h34;
    localparam logic [5:0] FnTne     = 6'h36;

    // REGIMM rt selectors
    localparam logic [4:0] RtBltz    = 5'h00;
    localparam logic [4:0] RtBgez    = 5'h01;
    localparam logic [4:0] RtBltzl   = 5'h02;
    localparam logic [4:0] RtBgezl   = 5'h03;
    localparam logic [4:0] RtTgei    = 5'h08;
    localparam logic [4:0] RtTgeiu   = 5'h09;
    localparam logic [4:0] RtTlti    = 5'h0A;
    localparam logic [4:0] RtTltiu   = 5'h0B;
    localparam logic [4:0] RtTeqi    = 5'h0C;
    localparam logic [4:0] RtTnei    = 5'h0E;
    localparam logic [4:0] RtBltzal  = 5'h10;
    localparam logic [4:0] RtBgezal  = 5'h11;
    localparam logic [4:0] RtBltzall = 5'h12;
    localparam logic [4:0] RtBgezall = 5'h13;

    // COP0 rs selectors and CO-space funct
    localparam logic [4:0] CopMf     = 5'h00;
    localparam logic [4:0] CopMt     = 5'h04;
    localparam logic [5:0] FnEret    = 6'h18;

    typedef enum logic [3:0] {
        ClsNop    = 4'd0,
        ClsCalr   = 4'd1,
        ClsCali   = 4'd2,
        ClsLoad   = 4'd3,
        ClsStore  = 4'd4,
        ClsBranch = 4'd5,
        ClsJump   = 4'd6,
        ClsShift  = 4'd7,
        ClsMulDiv = 4'd8,
        ClsMfHiLo = 4'd9,
        ClsMtHiLo = 4'd10,
        ClsMfc0   = 4'd11,
        ClsMtc0   = 4'd12,
        ClsTrap   = 4'd13,
        ClsEret   = 4'd14,
        ClsSys    = 4'd15
    } instr_class_e;

    localparam logic [4:0] ExcNone = 5'd0;
    localparam logic [4:0] ExcSys  = 5'd8;
    localparam logic [4:0] ExcBp   = 5'd9;
    localparam logic [4:0] ExcRi   = 5'd10;

    // Classes that touch HI/LO and must wait for the mult/div unit
    function automatic logic uses_hilo(instr_class_e cls);
        return cls inside {ClsMulDiv, ClsMfHiLo, ClsMtHiLo};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational MIPS decode: destination register, class code, exception code
// and mult/div kind for one instruction word.
module instr_decode
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  dst_o,
    output logic [3:0]  cls_o,
    output logic [4:0]  exc_o,
    output logic        md_div_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = instr_i[31:26];
    assign rs     = instr_i[25:21];
    assign rt     = instr_i[20:16];
    assign rd     = instr_i[15:11];
    assign funct  = instr_i[5:0];

    instr_class_e cls;
    logic [4:0]   dst;
    logic [4:0]   exc;
    logic         md_div;
    logic         illegal;

    always_comb begin
        cls     = ClsNop;
        dst     = 5'd0;
        exc     = ExcNone;
        md_div  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OpSpecial: begin
                case (funct)
                    FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav: begin
                        // All-zero word is the canonical nop, not a shift
                        cls = (instr_i == 32'h0) ? ClsNop : ClsShift;
                        dst = rd;
                    end
                    FnJr:      cls = ClsJump;
                    FnJalr: begin
                        cls = ClsJump;
                        dst = rd;
                    end
                    FnSyscall: begin
                        cls = ClsSys;
                        exc = ExcSys;
                    end
                    FnBreak: begin
                        cls = ClsSys;
                        exc = ExcBp;
                    end
                    FnMfhi, FnMflo: begin
                        cls = ClsMfHiLo;
                        dst = rd;
                    end
                    FnMthi, FnMtlo:  cls = ClsMtHiLo;
                    FnMult, FnMultu: cls = ClsMulDiv;
                    FnDiv, FnDivu: begin
                        cls    = ClsMulDiv;
                        md_div = 1'b1;
                    end
                    FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
                    FnSlt, FnSltu: begin
                        cls = ClsCalr;
                        dst = rd;
                    end
                    FnTge, FnTgeu, FnTlt, FnTltu, FnTeq, FnTne: cls = ClsTrap;
                    default: illegal = 1'b1;
                endcase
            end
            OpRegimm: begin
                case (rt)
                    RtBltz, RtBgez, RtBltzl, RtBgezl: cls = ClsBranch;
                    RtBltzal, RtBgezal, RtBltzall, RtBgezall: begin
                        cls = ClsBranch;
                        dst = 5'd31;
                    end
                    RtTgei, RtTgeiu, RtTlti, RtTltiu, RtTeqi, RtTnei: cls = ClsTrap;
                    default: illegal = 1'b1;
                endcase
            end
            OpJ: cls = ClsJump;
            OpJal: begin
                cls = ClsJump;
                dst = 5'd31;
            end
            OpBeq, OpBne, OpBlez, OpBgtz, OpBeql, OpBnel, OpBlezl, OpBgtzl: cls = ClsBranch;
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
                cls = ClsCali;
                dst = rt;
            end
            OpCop0: begin
                case (rs)
                    CopMf: begin
                        cls = ClsMfc0;
                        dst = rt;
                    end
                    CopMt: cls = ClsMtc0;
                    default: begin
                        if (rs[4] && funct == FnEret) begin
                            cls = ClsEret;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu, OpLwr: begin
                cls = ClsLoad;
                dst = rt;
            end
            OpSb, OpSh, OpSwl, OpSw, OpSwr: cls = ClsStore;
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            cls    = ClsNop;
            dst    = 5'd0;
            exc    = ExcRi;
            md_div = 1'b0;
        end
    end

    assign dst_o    = dst;
    assign cls_o    = cls;
    assign exc_o    = exc;
    assign md_div_o = md_div;

endmodule

// File: rtl/decode_unit.sv
// Single-entry decode stage with valid/ready handshake and a mult/div busy
// counter that holds back HI/LO-dependent entries.
module decode_unit
    import decode_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [4:0]  out_dst,
    output logic [3:0]  out_class,
    output logic [4:0]  out_exc,
    output logic        md_busy
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

    logic [4:0] dec_dst;
    logic [3:0] dec_cls;
    logic [4:0] dec_exc;
    logic       dec_md_div;

    instr_decode u_instr_decode (
        .instr_i  (in_instr),
        .dst_o    (dec_dst),
        .cls_o    (dec_cls),
        .exc_o    (dec_exc),
        .md_div_o (dec_md_div)
    );

    logic             full_q, full_d;
    logic [31:0]      instr_q, instr_d;
    logic [4:0]       dst_q, dst_d;
    instr_class_e     cls_q, cls_d;
    logic [4:0]       exc_q, exc_d;
    logic             md_div_q, md_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic handoff;
    logic accept;
    logic hl_block;

    assign md_busy   = (cnt_q != '0);
    assign hl_block  = md_busy & uses_hilo(cls_q);
    assign out_valid = full_q & ~hl_block;
    assign handoff   = out_valid & out_ready;
    assign in_ready  = ~full_q | handoff;
    assign accept    = in_valid & in_ready & ~flush;

    always_comb begin
        full_d   = full_q;
        instr_d  = instr_q;
        dst_d    = dst_q;
        cls_d    = cls_q;
        exc_d    = exc_q;
        md_div_d = md_div_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d   = 1'b1;
            instr_d  = in_instr;
            dst_d    = dec_dst;
            cls_d    = instr_class_e'(dec_cls);
            exc_d    = dec_exc;
            md_div_d = dec_md_div;
        end else if (handoff) begin
            full_d = 1'b0;
        end
    end

    // A mult/div leaving the stage restarts the counter even during a flush
    always_comb begin
        cnt_d = cnt_q;
        if (handoff && cls_q == ClsMulDiv) begin
            cnt_d = md_div_q ? DivLoad : MultLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= 1'b0;
            instr_q  <= 32'h0;
            dst_q    <= 5'd0;
            cls_q    <= ClsNop;
            exc_q    <= ExcNone;
            md_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            full_q   <= full_d;
            instr_q  <= instr_d;
            dst_q    <= dst_d;
            cls_q    <= cls_d;
            exc_q    <= exc_d;
            md_div_q <= md_div_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_instr = instr_q;
    assign out_dst   = dst_q;
    assign out_class = cls_q;
    assign out_exc   = exc_q;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: directed instruction words with
// hand-decoded expectations, checked by a monitor at each handoff.
module tb_decode_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [4:0]  out_dst;
    logic [3:0]  out_class;
    logic [4:0]  out_exc;
    logic        md_busy;

    decode_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_dst   (out_dst),
        .out_class (out_class),
        .out_exc   (out_exc),
        .md_busy   (md_busy)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  dst;
        logic [3:0]  cls;
        logic [4:0]  exc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] w, input logic [4:0] d, input logic [3:0] c,
                         input logic [4:0] x);
        sb.push_back('{w, d, c, x});
        in_valid = 1'b1;
        in_instr = w;
        tick();
    endtask

    // Monitor: every handoff pops one expected entry
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got instr 0x%08h, required no output", out_instr);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("instr[%08h]", mon_e.instr), out_instr, mon_e.instr);
                check($sformatf("dst[%08h]", mon_e.instr), 32'(out_dst), 32'(mon_e.dst));
                check($sformatf("class[%08h]", mon_e.instr), 32'(out_class), 32'(mon_e.cls));
                check($sformatf("exc[%08h]", mon_e.instr), 32'(out_exc), 32'(mon_e.exc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'h0);
        reset = 1'b0;
        tick();

        // Streaming decode, one instruction per cycle
        out_ready = 1'b1;
        issue(32'h00221821, 5'd3,  4'd1,  5'd0);   // addu $3,$1,$2
        issue(32'hFC000000, 5'd0,  4'd0,  5'd10);  // undefined opcode
        issue(32'h0000000C, 5'd0,  4'd15, 5'd8);   // syscall
        issue(32'h0000000D, 5'd0,  4'd15, 5'd9);   // break
        issue(32'h8C250004, 5'd5,  4'd3,  5'd0);   // lw $5,4($1)
        issue(32'hAC250004, 5'd0,  4'd4,  5'd0);   // sw $5,4($1)
        issue(32'h24070001, 5'd7,  4'd2,  5'd0);   // addiu $7,$0,1
        issue(32'h0C000000, 5'd31, 4'd6,  5'd0);   // jal
        issue(32'h10220000, 5'd0,  4'd5,  5'd0);   // beq $1,$2
        issue(32'h04310000, 5'd31, 4'd5,  5'd0);   // bgezal $1
        issue(32'h04100000, 5'd31, 4'd5,  5'd0);   // bltzal $0
        issue(32'h04080000, 5'd0,  4'd13, 5'd0);   // tgei
        issue(32'h04040000, 5'd0,  4'd0,  5'd10);  // undefined regimm
        issue(32'h00031100, 5'd2,  4'd7,  5'd0);   // sll $2,$3,4
        issue(32'h00000000, 5'd0,  4'd0,  5'd0);   // nop
        issue(32'h00804809, 5'd9,  4'd6,  5'd0);   // jalr $9,$4
        issue(32'h40086000, 5'd8,  4'd11, 5'd0);   // mfc0 $8,$12
        issue(32'h40886000, 5'd0,  4'd12, 5'd0);   // mtc0 $8,$12
        issue(32'h42000018, 5'd0,  4'd14, 5'd0);   // eret
        issue(32'h00220034, 5'd0,  4'd13, 5'd0);   // teq $1,$2
        issue(32'h00200011, 5'd0,  4'd10, 5'd0);   // mthi $1
        issue(32'h00221801, 5'd0,  4'd0,  5'd10);  // undefined funct
        issue(32'h3C040000, 5'd4,  4'd2,  5'd0);   // lui $4
        issue(32'h40400000, 5'd0,  4'd0,  5'd10);  // undefined cop0 rs
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_drained", 32'(sb.size()), 32'd0);

        // mult then mflo: mflo held for exactly MULT_CYCLES cycles
        issue(32'h00220018, 5'd0, 4'd8, 5'd0);     // mult $1,$2
        issue(32'h00002012, 5'd4, 4'd9, 5'd0);     // mflo $4
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mult_busy_%0d", i), 32'(md_busy), 32'd1);
            check($sformatf("mflo_blocked_%0d", i), 32'(out_valid), 32'd0);
            tick();
        end
        check("mult_busy_done", 32'(md_busy), 32'd0);
        check("mflo_released", 32'(out_valid), 32'd1);
        tick();
        tick();

        // Backpressure: second word waits, first word stays stable
        out_ready = 1'b0;
        issue(32'h00221821, 5'd3, 4'd1, 5'd0);
        sb.push_back('{32'h24070001, 5'd7, 4'd2, 5'd0});
        in_instr = 32'h24070001;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold_%0d", i), out_instr, 32'h00221821);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_second", out_instr, 32'h24070001);
        tick();
        tick();

        // Flush with held entry and new input; divide counter keeps running
        issue(32'h0022001B, 5'd0, 4'd8, 5'd0);     // divu $1,$2
        issue(32'h00804809, 5'd9, 4'd6, 5'd0);     // jalr, handed off during flush
        check("flush_pre_busy", 32'(md_busy), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h3C040000;                   // discarded by flush
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(md_busy), 32'd1);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("div_busy_%0d", i), 32'(md_busy), 32'd1);
        end
        tick();
        check("div_busy_done", 32'(md_busy), 32'd0);
        check("flush_no_entry", 32'(out_valid), 32'd0);

        // Div handed off during flush still loads the counter; reset kills it
        issue(32'h0022001A, 5'd0, 4'd8, 5'd0);     // div $1,$2
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("flushdiv_busy", 32'(md_busy), 32'd1);
        check("flushdiv_empty", 32'(out_valid), 32'd0);
        tick();
        tick();
        reset    = 1'b1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00221821;
        tick();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("mid_div_rst_busy", 32'(md_busy), 32'd0);
        check("mid_div_rst_valid", 32'(out_valid), 32'd0);
        check("mid_div_rst_ready", 32'(in_ready), 32'd1);

        issue(32'h8C250004, 5'd5, 4'd3, 5'd0);
        in_valid = 1'b0;
        tick();
        tick();
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu after handoff.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu after handoff.
REQ-003 SHALL have parameter CNT_W, default 4: busy-counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_instr is valid.
REQ-007 SHALL have port in_instr, input, 32 bits: MIPS instruction word.
REQ-008 SHALL have port in_ready, output, 1 bit: the unit accepts in_instr this cycle.
REQ-009 SHALL have port flush, input, 1 bit: discard the held entry.
REQ-010 SHALL have port out_valid, output, 1 bit: the decoded entry is presented downstream.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the entry.
REQ-012 SHALL have port out_instr, output, 32 bits: the held instruction word.
REQ-013 SHALL have port out_dst, output, 5 bits: GPR write destination (0 = none).
REQ-014 SHALL have port out_class, output, 4 bits: instruction class code (see REQ-019).
REQ-015 SHALL have port out_exc, output, 5 bits: ExcCode (0 = none, 8 = Syscall, 9 = Bp, 10 = RI).
REQ-016 SHALL have port md_busy, output, 1 bit: the mult/div unit is busy.

Function
REQ-017 SHALL hold one registered entry (full flag plus instr, dst, class and exc fields); handoff occurs when out_valid & out_ready.
REQ-018 SHALL drive in_ready = ~full | handoff; on in_valid & in_ready & ~flush, the entry SHALL load the decode of in_instr at the next edge.
REQ-019 SHALL encode out_class as follows:
- 0 nop/other, 1 calr, 2 cali, 3 load, 4 store, 5 branch, 6 jump;
- 7 shift (shamt or reg), 8 mult/div, 9 mfhi/mflo, 10 mthi/mtlo;
- 11 mfc0, 12 mtc0, 13 trap (reg/imm), 14 eret, 15 syscall/break.
REQ-020 SHALL compute dst as follows:
- 31 for jal/bgezal/bltzal/bgezall/bltzall;
- rd for R-type writers, jalr and mfhi/mflo;
- rt for I-type writers, loads and mfc0;
- otherwise 0.
REQ-021 SHALL set out_exc to 10 for any unrecognised encoding, to 8 for syscall and to 9 for break; an unrecognised instruction SHALL have out_class 0 and out_dst 0.
REQ-022 SHALL drive out_valid = full & ~hl_block, where hl_block = md_busy & (held class is 8, 9 or 10).
REQ-023 SHALL load the busy counter on handoff of a class-8 entry: MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
REQ-024 SHALL otherwise decrement the busy counter while it is non-zero, saturating at 0; a load and a decrement in the same cycle SHALL resolve as the load.
REQ-025 SHALL drive md_busy = (counter != 0); a class-9 or class-10 entry following a mult SHALL therefore be presented exactly MULT_CYCLES cycles after the mult handoff.
REQ-026 SHALL clear full at the next edge on flush, discarding any simultaneous input; a handoff in the flush cycle SHALL still count as taken, including any resulting counter load.
REQ-027 SHALL leave the busy counter unaffected by flush.
REQ-028 SHALL hold the entry's fields stable while full & ~handoff.
REQ-029 SHALL, on handoff with a simultaneous accept, replace the entry with no bubble; with no accept, full SHALL clear.

Reset
REQ-030 SHALL, on reset, clear full, the counter and all entry fields to 0, giving out_valid=0, md_busy=0, in_ready=1 in the following cycle.
REQ-031 SHALL let reset override flush, in_valid and any counter activity, including mid-divide.

Structure
REQ-032 SHALL take opcode/funct/regimm constants, the class codes and the ExcCode values from a shared package, decode_pkg.
REQ-033 SHALL place the combinational decode (instruction in; dst, class, exc and md-kind out) in the sub-module instr_decode; decode_unit SHALL contain only the register, handshake and counter.

Verification
REQ-034 SHALL cover: addu $3,$1,$2 (0x00221821), in_valid=1, out_ready=1 -> the next cycle has out_valid=1, out_dst=3, out_class=1, out_exc=0.
REQ-035 SHALL cover: mult (0x00220018) then mflo $4 (0x00002012) back-to-back, MULT_CYCLES=5 -> md_busy=1 for 5 cycles and mflo out_valid=0 throughout, then out_valid=1 with out_dst=4.
REQ-036 SHALL cover: out_ready=0 with two valid inputs -> in_ready=0 after the first is accepted; out_instr stays at the first word until out_ready=1.
REQ-037 SHALL cover: 0xFC000000 -> out_exc=10, out_class=0; 0x0000000C -> out_exc=8; 0x0000000D -> out_exc=9.
REQ-038 SHALL cover: flush with a full entry and in_valid=1 in the same cycle -> out_valid=0 the next cycle, with the md counter value unchanged.
REQ-039 SHALL cover: reset asserted 3 cycles after a div handoff (DIV_CYCLES=10) -> md_busy=0 and out_valid=0 the next cycle.
